// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Every access runs as a fixed IDLE/ISSUE/(CAPTURE)/ACK transaction, and all outputs are registered.
module ram_arbiter #(
    parameter int A = 10,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         r0_req,
    input  logic         r0_rw,
    input  logic [A-1:0] r0_addr,
    input  logic [D-1:0] r0_wdata,
    output logic [D-1:0] r0_rdata,
    output logic         r0_ack,
    input  logic         r1_req,
    input  logic         r1_rw,
    input  logic [A-1:0] r1_addr,
    input  logic [D-1:0] r1_wdata,
    output logic [D-1:0] r1_rdata,
    output logic         r1_ack,
    output logic         ram_cs,
    output logic         ram_rw,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_wdata,
    input  logic [D-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        ACK
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic           r_gnt;
    logic           r_last;
    logic           w_gnt_nx;
    logic           w_last_nx;
    logic           w_win;
    logic           w_cs_nx;
    logic           w_rw_nx;
    logic [A-1:0]   w_addr_nx;
    logic [D-1:0]   w_wdata_nx;
    logic [D-1:0]   w_rd0_nx;
    logic [D-1:0]   w_rd1_nx;
    logic           w_ack0_nx;
    logic           w_ack1_nx;

    // On a tie the requester that did not win last time gets the grant.
    assign w_win = (r0_req && r1_req) ? ~r_last : r1_req;

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_last_nx  = r_last;
        w_cs_nx    = 1'b0;
        w_rw_nx    = ram_rw;
        w_addr_nx  = ram_addr;
        w_wdata_nx = ram_wdata;
        w_rd0_nx   = r0_rdata;
        w_rd1_nx   = r1_rdata;
        w_ack0_nx  = 1'b0;
        w_ack1_nx  = 1'b0;

        case (r_state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    w_gnt_nx   = w_win;
                    w_last_nx  = w_win;
                    w_cs_nx    = 1'b1;
                    w_rw_nx    = w_win ? r1_rw    : r0_rw;
                    w_addr_nx  = w_win ? r1_addr  : r0_addr;
                    w_wdata_nx = w_win ? r1_wdata : r0_wdata;
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_rw) begin
                    w_state_nx = CAPTURE;
                end else begin
                    w_ack0_nx  = ~r_gnt;
                    w_ack1_nx  = r_gnt;
                    w_state_nx = ACK;
                end
            end
            CAPTURE: begin
                if (r_gnt) begin
                    w_rd1_nx = ram_rdata;
                end else begin
                    w_rd0_nx = ram_rdata;
                end
                w_ack0_nx  = ~r_gnt;
                w_ack1_nx  = r_gnt;
                w_state_nx = ACK;
            end
            ACK: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Reset abandons any in-flight access: the strobe and acks drop at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            ram_cs    <= 1'b0;
            ram_rw    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_gnt     <= w_gnt_nx;
            r_last    <= w_last_nx;
            ram_cs    <= w_cs_nx;
            ram_rw    <= w_rw_nx;
            ram_addr  <= w_addr_nx;
            ram_wdata <= w_wdata_nx;
            r0_rdata  <= w_rd0_nx;
            r1_rdata  <= w_rd1_nx;
            r0_ack    <= w_ack0_nx;
            r1_ack    <= w_ack1_nx;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a transaction-level model predicts grant order,
// ack cycle and read data; a negedge monitor checks every ack and the bus protocol.
module tb_ram_arbiter;

    localparam int A = 10;
    localparam int D = 8;

    typedef struct {
        logic         rw;
        logic [A-1:0] addr;
        logic [D-1:0] wd;
    } txn_t;

    typedef struct {
        int           id;
        longint       cyc;
        logic [D-1:0] rd0;
        logic [D-1:0] rd1;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         r0_req = 1'b0, r1_req = 1'b0;
    logic         r0_rw = 1'b0, r1_rw = 1'b0;
    logic [A-1:0] r0_addr = '0, r1_addr = '0;
    logic [D-1:0] r0_wdata = '0, r1_wdata = '0;
    logic [D-1:0] r0_rdata, r1_rdata;
    logic         r0_ack, r1_ack;
    logic         ram_cs, ram_rw;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_wdata;
    logic [D-1:0] ram_rdata = '0;

    logic [D-1:0] mem [2**A] = '{default: '0};
    longint       cyc = 0;

    // Reference model state
    logic [D-1:0] ref_mem [2**A] = '{default: '0};
    int           ref_last = 1;
    logic [D-1:0] ref_rd [2] = '{default: '0};

    exp_t sb[$];
    txn_t q0[$], q1[$];

    int   n_vec = 0, n_err = 0;
    int   rst_req = 0, tmo_cnt = 0, done_req = 0;
    logic snap_cs = 1'b0, snap_ack = 1'b0;

    ram_arbiter #(.A(A), .D(D)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_ack(r1_ack),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM with registered read data
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_rw) ram_rdata <= mem[ram_addr];
            else        mem[ram_addr] <= ram_wdata;
        end
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor / scoreboard
    initial begin
        int   rst_seen = 0, tmo_seen = 0, done_seen = 0;
        logic prev_cs = 1'b0, prev_ack = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_req != rst_seen) begin
                rst_seen = rst_req;
                chk("rst_cs_immediate", {63'd0, snap_cs}, 64'd0);
                chk("rst_ack_immediate", {63'd0, snap_ack}, 64'd0);
                chk("rst_outputs", {26'd0, ram_cs, ram_rw, ram_addr, ram_wdata,
                                    r0_rdata, r1_rdata, r0_ack, r1_ack}, 64'd0);
                chk("rst_no_pending", 64'(sb.size()), 64'd0);
            end
            if (tmo_cnt != tmo_seen) begin
                tmo_seen = tmo_cnt;
                chk("batch_timeout", 64'd1, 64'd0);
            end
            if (!reset) begin
                if (ram_cs) chk("cs_single_cycle", {63'd0, prev_cs}, 64'd0);
                if (r0_ack || r1_ack) begin
                    chk("ack_onehot", {63'd0, r0_ack & r1_ack}, 64'd0);
                    chk("ack_single_cycle", {63'd0, prev_ack}, 64'd0);
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", {63'd0, r1_ack}, 64'd2);
                    end else begin
                        e = sb.pop_front();
                        chk("grant_id", {63'd0, r1_ack}, 64'(e.id));
                        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                        chk("r0_rdata", {56'd0, r0_rdata}, {56'd0, e.rd0});
                        chk("r1_rdata", {56'd0, r1_rdata}, {56'd0, e.rd1});
                    end
                end
            end
            if (done_req != done_seen) begin
                done_seen = done_req;
                chk("all_acks_seen", 64'(sb.size()), 64'd0);
            end
            prev_cs  = ram_cs;
            prev_ack = r0_ack | r1_ack;
        end
    end

    task automatic drive(input int n, input txn_t x);
        if (n == 0) begin
            r0_rw = x.rw; r0_addr = x.addr; r0_wdata = x.wd; r0_req = 1'b1;
        end else begin
            r1_rw = x.rw; r1_addr = x.addr; r1_wdata = x.wd; r1_req = 1'b1;
        end
    endtask

    // Both requesters start in the same IDLE cycle and re-request right after each ack.
    task automatic run_batch();
        longint c0, t;
        int     i0 = 0, i1 = 0, w, budget;
        txn_t   x;
        exp_t   e;
        @(negedge clk);
        c0 = cyc;
        t  = c0;
        while (i0 < q0.size() || i1 < q1.size()) begin
            if (i0 < q0.size() && i1 < q1.size()) w = 1 - ref_last;
            else if (i0 < q0.size())              w = 0;
            else                                  w = 1;
            if (w == 0) begin x = q0[i0]; i0++; end
            else        begin x = q1[i1]; i1++; end
            ref_last = w;
            if (x.rw) begin
                ref_rd[w] = ref_mem[x.addr];
                e.cyc = t + 3;
                t += 4;
            end else begin
                ref_mem[x.addr] = x.wd;
                e.cyc = t + 2;
                t += 3;
            end
            e.id = w; e.rd0 = ref_rd[0]; e.rd1 = ref_rd[1];
            sb.push_back(e);
        end
        budget = 4 * (q0.size() + q1.size()) + 8;
        if (q0.size() > 0) drive(0, q0[0]);
        if (q1.size() > 0) drive(1, q1[0]);
        for (int k = 0; k < budget && (q0.size() > 0 || q1.size() > 0); k++) begin
            @(negedge clk);
            if (r0_ack && q0.size() > 0) begin
                void'(q0.pop_front());
                if (q0.size() > 0) drive(0, q0[0]); else r0_req = 1'b0;
            end
            if (r1_ack && q1.size() > 0) begin
                void'(q1.pop_front());
                if (q1.size() > 0) drive(1, q1[0]); else r1_req = 1'b0;
            end
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            tmo_cnt++;
            q0.delete(); q1.delete();
            r0_req = 1'b0; r1_req = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        snap_cs  = ram_cs;
        snap_ack = r0_ack | r1_ack;
        rst_req++;
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ref_last = 1;
        ref_rd   = '{default: '0};
    endtask

    function automatic txn_t mk(input logic rw, input logic [A-1:0] addr, input logic [D-1:0] wd);
        txn_t x;
        x.rw = rw; x.addr = addr; x.wd = wd;
        return x;
    endfunction

    function automatic txn_t rnd_txn();
        logic [A-1:0] pool [5] = '{10'h000, 10'h001, 10'h002, 10'h3FF, 10'h010};
        logic [A-1:0] a;
        if ($urandom_range(0, 1) == 0) a = pool[$urandom_range(0, 4)];
        else                           a = A'($urandom);
        return mk(1'($urandom), a, D'($urandom));
    endfunction

    initial begin
        int n0, n1;
        repeat (2) @(negedge clk);
        do_reset();

        q0 = '{mk(1'b0, 10'h001, 8'h11)};
        q1 = '{mk(1'b0, 10'h002, 8'h22)};
        run_batch();
        // Tie with r1 last granted: r0 first (ack T3), r1 second (ack T7)
        q0 = '{mk(1'b1, 10'h001, 8'h00)};
        q1 = '{mk(1'b1, 10'h002, 8'h00)};
        run_batch();
        // r0 holds req after ack: write then read back, r1_rdata stays 0x22
        q0 = '{mk(1'b0, 10'h010, 8'hA5), mk(1'b1, 10'h010, 8'h00)};
        run_batch();
        // Sustained contention: strict alternation
        for (int k = 0; k < 4; k++) begin
            q0.push_back(rnd_txn());
            q1.push_back(rnd_txn());
        end
        run_batch();
        for (int b = 0; b < 30; b++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) q0.push_back(rnd_txn());
            for (int k = 0; k < n1; k++) q1.push_back(rnd_txn());
            run_batch();
        end

        // Reset in the ISSUE cycle of a write to 0x005
        q1 = '{mk(1'b0, 10'h005, 8'h5A), mk(1'b1, 10'h005, 8'h00)};
        run_batch();
        @(negedge clk);
        drive(0, mk(1'b0, 10'h005, 8'h77));
        begin
            int k;
            for (k = 0; k < 8; k++) begin
                @(negedge clk);
                if (ram_cs) break;
            end
            if (k == 8) tmo_cnt++;
        end
        #2;
        do_reset();
        @(negedge clk);

        // After reset last=1: r0 write granted first, r1 reads the top address back
        q0 = '{mk(1'b0, 10'h3FF, 8'h3C)};
        q1 = '{mk(1'b1, 10'h3FF, 8'h00)};
        run_batch();
        q1 = '{mk(1'b1, 10'h005, 8'h00)};
        run_batch();

        repeat (3) @(negedge clk);
        done_req++;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter that shares a single-port synchronous `ram` instance between two requesters, e.g. CPU and DMA/video fetch. It sequences every access as a fixed multi-cycle transaction on the RAM's `cs`/`rw`/`addr`/`data_in` pins. It captures the RAM's registered read data and returns it to the winning requester with a one-cycle `ack` pulse. It sits between the requesters and the RAM; nothing else drives the RAM pins.

## Interface
Parameters:
- `A`, 10, address width; must match the RAM's `A`.
- `D`, 8, data width; must match the RAM's `D`.

Ports:
- `clk`  in  1  single clock; all logic samples on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `r0_req`, `r1_req`  in  1  access request; held high until the matching `ack`.
- `r0_rw`, `r1_rw`  in  1  1 = read, 0 = write; stable while `req` is high.
- `r0_addr`, `r1_addr`  in  A  word address; stable while `req` is high.
- `r0_wdata`, `r1_wdata`  in  D  write data; stable while `req` is high.
- `r0_rdata`, `r1_rdata`  out  D  read data register; valid from that requester's read `ack` until its next read `ack`.
- `r0_ack`, `r1_ack`  out  1  one-cycle completion pulse.
- `ram_cs`  out  1  to RAM `cs`.
- `ram_rw`  out  1  to RAM `rw`.
- `ram_addr`  out  A  to RAM `addr`.
- `ram_wdata`  out  D  to RAM `data_in`.
- `ram_rdata`  in  D  from RAM `data_out`; valid the cycle after a read strobe.

## Operation
- **Output registers.** All outputs are registered. Reset clears every output to 0, clears `state` to IDLE and sets `last` (last-granted pointer) to 1, so requester 0 wins the first tie.
- **FSM states.** IDLE, ISSUE, CAPTURE, ACK.
- **IDLE.** Requests are sampled only in this state.
  - If exactly one `req` is high, grant it.
  - If both are high, grant `~last`.
  - On grant, set `gnt` to the winner and `last` to the winner.
  - Load `ram_cs`=1 and `ram_rw`/`ram_addr`/`ram_wdata` from the winner, then go to ISSUE.
  - With no request, stay in IDLE with `ram_cs`=0.
- **ISSUE.** `ram_cs` is high for exactly this one cycle, and the RAM acts at the edge ending ISSUE.
  - Next state: CAPTURE for a read, ACK for a write.
  - `ram_cs` is cleared at the same edge.
- **CAPTURE (reads only).**
  - `ram_rdata` is valid.
  - At the edge ending CAPTURE, load `r<gnt>_rdata` from `ram_rdata`; the other requester's `rdata` is unchanged.
  - Set `r<gnt>_ack`, then go to ACK.
- **ACK.** `r<gnt>_ack`=1 for this one cycle only.
  - For writes, the ack is set at the edge ending ISSUE.
  - At the edge ending ACK, clear the ack and go to IDLE.
- **Requester rule.** A requester drops `req` at the edge ending its ACK cycle. A `req` still high in the following IDLE is a new transaction.
- **Fairness.** While one requester waits, at most one transaction of the other completes before it is granted.
- **Other signals.**
  - While `ram_cs` is 0, `ram_rw`/`ram_addr`/`ram_wdata` hold their last values.
  - `rw` and `addr` of a non-granted requester are ignored.
- **Address width.** `A` bits pass through unmodified; there is no wrap or translation logic.

## Timing
- Read latency: `req` high in IDLE cycle T0, ISSUE in T1, CAPTURE in T2, `ack` and `rdata` valid in T3.
- Read throughput: 4 cycles per access.
- Write latency: IDLE in T0, ISSUE in T1 (RAM writes at the end of T1), `ack` in T2.
- Write throughput: 3 cycles per access.
- A request arriving while the FSM is busy waits; its worst-case wait before ISSUE is one full read transaction of the other requester plus the IDLE cycle.
- **Simultaneous events.**
  - A request arriving in the ACK cycle of the other requester is granted in the next IDLE.
  - Both requests arriving in the same IDLE are resolved by `last`.
- **Reset mid-operation.** Asynchronous assertion forces IDLE, `ram_cs`=0 and all acks to 0 immediately, and abandons the in-flight transaction.
  - If reset is asserted during ISSUE before the clock edge, the write does not occur.
  - No ack is ever issued for an abandoned transaction.
  - `rdata` registers clear to 0.

## Test plan
- **Reset values.** Assert `reset` mid-ISSUE of a write to 0x005 -> `ram_cs` drops immediately, RAM 0x005 is unchanged, all outputs read 0, and the first request after release is served from IDLE.
- **Single write then read, requester 0.** Write 0xA5 to 0x010 -> `r0_ack` two cycles after the IDLE sample. Then read 0x010 -> `r0_ack` three cycles after the sample, `r0_rdata`=0xA5, and `r1_rdata` is unchanged.
- **Tie after reset.** Both requesters read at once, r0 to 0x001 and r1 to 0x002 -> r0 is served first (ack at T3) and r1 second (ack at T7), with the correct data each.
- **Alternation under sustained contention.** Both requesters re-request immediately after each ack for 8 transactions -> grants strictly alternate r1,r0,r1,... after the first r0 grant, with no back-to-back grants to the same requester.
- **Mixed write/read hazard.** r0 writes 0x3C to 0x3FF while r1 reads 0x3FF pending -> r1 (granted second) returns 0x3C, confirming the ordering and top-address handling.
- **Protocol check.** A requester holds `req` high after `ack` -> a second full transaction is performed. A monitor asserts that `ram_cs` is never high for two consecutive cycles and that acks are one-hot single-cycle pulses.
